// File: rtl/seven_segment_capture.sv
// Receive side of an 8-digit multiplexed seven-segment scan: samples stable digits,
// decodes hex glyphs and hands complete frames out over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WAIT_D0 | idle, discarding samples until digit 0 settles
// COLLECT | digits 0..expect-1 stored, waiting for digit `expect`
// PUBLISH | frame complete, move slots to the output buffer or drop it
module seven_segment_capture #(
    parameter int SETTLE_CYCLES = 16,
    parameter int TIMEOUT       = 400_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [6:0]  cat_in,
    input  logic [7:0]  an_in,
    input  logic        ready_in,
    output logic        frame_valid_out,
    output logic [55:0] seg_frame_out,
    output logic [31:0] digit_frame_out,
    output logic [7:0]  unknown_out,
    output logic [7:0]  err_count_out
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {WAIT_D0, COLLECT, PUBLISH} state_t;

    state_t      state;
    logic [6:0]  cat_s1, cat_s2;
    logic [7:0]  an_s1, an_s2;
    logic [6:0]  seg_now, seg_r;
    logic [7:0]  act_now, act_r;
    logic [SW-1:0] stab_cnt;
    logic        sampled;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]  expect_idx;
    logic [6:0]  seg_slot [8];
    logic [3:0]  val_slot [8];
    logic [7:0]  unk_slot;

    logic        sample, legal, hit, repeat_hit, restart, abort_evt, drop_evt;
    logic [2:0]  idx;
    logic [4:0]  dec;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h77:   decode = 5'h0A;
            7'h7C:   decode = 5'h0B;
            7'h39:   decode = 5'h0C;
            7'h5E:   decode = 5'h0D;
            7'h79:   decode = 5'h0E;
            7'h71:   decode = 5'h0F;
            default: decode = 5'h1F;
        endcase
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [7:0] a);
        onehot_idx = '0;
        for (int i = 0; i < 8; i++)
            if (a[i]) onehot_idx = 3'(i);
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cat_s1 <= '0;
            cat_s2 <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
        end else begin
            cat_s1 <= cat_in;
            cat_s2 <= cat_s1;
            an_s1  <= an_in;
            an_s2  <= an_s1;
        end
    end

    assign seg_now = ~cat_s2;
    assign act_now = ~an_s2;

    // Blanking cycles freeze the stability tracker, so act_r/seg_r always hold the
    // last driven digit and a sample fires once per activation.
    assign sample = (act_r != '0) && (stab_cnt == SETTLE_LAST) && !sampled;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            act_r    <= '0;
            seg_r    <= '0;
            stab_cnt <= '0;
            sampled  <= 1'b0;
        end else if (act_now != '0 && (act_now != act_r || seg_now != seg_r)) begin
            act_r    <= act_now;
            seg_r    <= seg_now;
            stab_cnt <= '0;
            sampled  <= 1'b0;
        end else begin
            if (act_now != '0 && stab_cnt != SETTLE_LAST)
                stab_cnt <= stab_cnt + SW'(1);
            if (sample)
                sampled <= 1'b1;
        end
    end

    always_comb begin
        legal      = $onehot(act_r);
        idx        = onehot_idx(act_r);
        dec        = decode(seg_r);
        hit        = sample && legal && (idx == expect_idx);
        repeat_hit = sample && legal && (idx == expect_idx - 3'd1);
        restart    = sample && legal && (idx == 3'd0);
        abort_evt  = (state == COLLECT) &&
                     ((sample && !hit && !repeat_hit) || (!sample && tmo_cnt == '0));
        drop_evt   = (state == PUBLISH) && frame_valid_out && !ready_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= WAIT_D0;
            expect_idx      <= '0;
            tmo_cnt         <= '0;
            unk_slot        <= '0;
            for (int i = 0; i < 8; i++) begin
                seg_slot[i] <= '0;
                val_slot[i] <= '0;
            end
            frame_valid_out <= 1'b0;
            seg_frame_out   <= '0;
            digit_frame_out <= '0;
            unknown_out     <= '0;
        end else begin
            if (frame_valid_out && ready_in)
                frame_valid_out <= 1'b0;
            case (state)
                WAIT_D0: begin
                    if (restart) begin
                        seg_slot[0] <= seg_r;
                        val_slot[0] <= dec[3:0];
                        unk_slot[0] <= dec[4];
                        expect_idx  <= 3'd1;
                        tmo_cnt     <= TMO_LOAD;
                        state       <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (abort_evt) begin
                        for (int i = 0; i < 8; i++) begin
                            seg_slot[i] <= '0;
                            val_slot[i] <= '0;
                        end
                        unk_slot <= '0;
                        // The offending sample may itself be the start of a new frame.
                        if (restart) begin
                            seg_slot[0] <= seg_r;
                            val_slot[0] <= dec[3:0];
                            unk_slot[0] <= dec[4];
                            expect_idx  <= 3'd1;
                            tmo_cnt     <= TMO_LOAD;
                        end else begin
                            state <= WAIT_D0;
                        end
                    end else if (hit) begin
                        seg_slot[idx] <= seg_r;
                        val_slot[idx] <= dec[3:0];
                        unk_slot[idx] <= dec[4];
                        tmo_cnt       <= TMO_LOAD;
                        if (expect_idx == 3'd7)
                            state <= PUBLISH;
                        else
                            expect_idx <= expect_idx + 3'd1;
                    end else if (tmo_cnt != '0) begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                PUBLISH: begin
                    if (!frame_valid_out || ready_in) begin
                        for (int i = 0; i < 8; i++) begin
                            seg_frame_out[i*7 +: 7]   <= seg_slot[i];
                            digit_frame_out[i*4 +: 4] <= val_slot[i];
                        end
                        unknown_out     <= unk_slot;
                        frame_valid_out <= 1'b1;
                    end
                    state <= WAIT_D0;
                end
                default: state <= WAIT_D0;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            err_count_out <= '0;
        else if ((abort_evt || drop_evt) && err_count_out != 8'hFF)
            err_count_out <= err_count_out + 8'd1;
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed + randomized bench for seven_segment_capture; expected frames come from
// a glyph-table model of the scanned digits.
module tb_seven_segment_capture;

    localparam int TMO     = 1000;
    localparam int DIG_CYC = 100;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [6:0]  cat_in;
    logic [7:0]  an_in;
    logic        ready_in;
    logic        frame_valid_out;
    logic [55:0] seg_frame_out;
    logic [31:0] digit_frame_out;
    logic [7:0]  unknown_out;
    logic [7:0]  err_count_out;

    int checks = 0;
    int errors = 0;
    int n_valid, n_accept, exp_err;
    logic [55:0] cap_seg;
    logic [31:0] cap_dig;
    logic [7:0]  cap_unk;
    logic [55:0] fa, fb;

    always #5 clk_in = ~clk_in;

    seven_segment_capture #(.SETTLE_CYCLES(16), .TIMEOUT(TMO)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .cat_in          (cat_in),
        .an_in           (an_in),
        .ready_in        (ready_in),
        .frame_valid_out (frame_valid_out),
        .seg_frame_out   (seg_frame_out),
        .digit_frame_out (digit_frame_out),
        .unknown_out     (unknown_out),
        .err_count_out   (err_count_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] g);
        lookup = -1;
        for (int k = 15; k >= 0; k--)
            if (GLYPH[k] == g) lookup = k;
    endfunction

    function automatic logic [55:0] segs_of(input logic [31:0] vals);
        logic [55:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s[i*7 +: 7] = GLYPH[vals[i*4 +: 4]];
        return s;
    endfunction

    function automatic logic [31:0] ref_digits(input logic [55:0] s);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 8; i++)
            d[i*4 +: 4] = (lookup(s[i*7 +: 7]) < 0) ? 4'hF : 4'(lookup(s[i*7 +: 7]));
        return d;
    endfunction

    function automatic logic [7:0] ref_unknown(input logic [55:0] s);
        logic [7:0] u;
        u = '0;
        for (int i = 0; i < 8; i++) u[i] = (lookup(s[i*7 +: 7]) < 0);
        return u;
    endfunction

    function automatic logic [55:0] rand_frame(input bit table_only);
        logic [55:0] s;
        s = '0;
        for (int i = 0; i < 8; i++)
            s[i*7 +: 7] = (table_only || $urandom_range(0, 1) == 1) ? GLYPH[$urandom_range(0, 15)]
                                                                      : 7'($urandom);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (frame_valid_out) begin
            n_valid++;
            cap_seg = seg_frame_out;
            cap_dig = digit_frame_out;
            cap_unk = unknown_out;
            if (ready_in) n_accept++;
        end
    endtask

    task automatic clear_mon();
        n_valid = 0; n_accept = 0; cap_seg = '0; cap_dig = '0; cap_unk = '0;
    endtask

    task automatic drive_digit(input int d, input logic [6:0] seg, input int cycles);
        an_in  = ~(8'(1) << d);
        cat_in = ~seg;
        repeat (cycles) tick();
    endtask

    task automatic blank(input int cycles);
        an_in  = 8'hFF;
        cat_in = 7'h7F;
        repeat (cycles) tick();
    endtask

    task automatic scan_frame(input logic [55:0] s);
        for (int i = 0; i < 8; i++) drive_digit(i, s[i*7 +: 7], DIG_CYC);
        blank(20);
    endtask

    task automatic check_frame(input string tag, input logic [55:0] s);
        check({tag, "_valid_cycles"}, 64'(n_valid), 64'd1);
        check({tag, "_digits"}, 64'(cap_dig), 64'(ref_digits(s)));
        check({tag, "_unknown"}, 64'(cap_unk), 64'(ref_unknown(s)));
        check({tag, "_segs"}, 64'(cap_seg), 64'(s));
    endtask

    initial begin
        an_in = 8'hFF; cat_in = 7'h7F; ready_in = 1'b1; exp_err = 0;
        clear_mon();
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_outputs", 64'({frame_valid_out, unknown_out, err_count_out, digit_frame_out}), 64'd0);
        check("reset_segs", 64'(seg_frame_out), 64'd0);
        #2 rst_in = 1'b0;
        blank(10);
        check("idle_valid", 64'(frame_valid_out), 64'd0);

        // Plain hex frame, consumer always ready.
        clear_mon();
        fa = segs_of(32'h7654_3210);
        scan_frame(fa);
        check("t1_accepts", 64'(n_accept), 64'd1);
        check("t1_digits_literal", 64'(cap_dig), 64'h7654_3210);
        check_frame("t1", fa);

        // Unknown glyph on digit 3.
        clear_mon();
        fa[27:21] = 7'h55;
        scan_frame(fa);
        check("t2_unknown_literal", 64'(cap_unk), 64'h08);
        check("t2_digit3", 64'(cap_dig[15:12]), 64'hF);
        check("t2_seg3", 64'(cap_seg[27:21]), 64'h55);
        check_frame("t2", fa);

        for (int r = 0; r < 4; r++) begin
            clear_mon();
            fa = rand_frame(1'b0);
            scan_frame(fa);
            check_frame("rand", fa);
        end
        check("rand_err", 64'(err_count_out), 64'(exp_err));

        // Held frame, second frame dropped.
        ready_in = 1'b0;
        clear_mon();
        fa = rand_frame(1'b1);
        fb = ~fa & {8{7'h7F}};
        scan_frame(fa);
        scan_frame(fb);
        exp_err++;
        check("t3_held_valid", 64'(frame_valid_out), 64'd1);
        check("t3_held_digits", 64'(cap_dig), 64'(ref_digits(fa)));
        check("t3_held_segs", 64'(seg_frame_out), 64'(fa));
        check("t3_drop_err", 64'(err_count_out), 64'(exp_err));
        ready_in = 1'b1;
        tick();
        check("t3_release", 64'(frame_valid_out), 64'd0);

        // Out-of-order digit aborts, next clean frame intact.
        clear_mon();
        drive_digit(0, GLYPH[0], DIG_CYC);
        drive_digit(1, GLYPH[1], DIG_CYC);
        drive_digit(3, GLYPH[3], DIG_CYC);
        blank(20);
        exp_err++;
        check("t4_err", 64'(err_count_out), 64'(exp_err));
        check("t4_no_frame", 64'(n_valid), 64'd0);
        fa = rand_frame(1'b0);
        scan_frame(fa);
        check_frame("t4_clean", fa);

        // Two anodes active long enough to settle.
        clear_mon();
        drive_digit(0, GLYPH[0], DIG_CYC);
        drive_digit(1, GLYPH[1], DIG_CYC);
        an_in = 8'b1111_1100;
        cat_in = ~GLYPH[5];
        repeat (20) tick();
        blank(20);
        exp_err++;
        check("t5_illegal_err", 64'(err_count_out), 64'(exp_err));
        check("t5_no_frame", 64'(n_valid), 64'd0);

        // Short glitches: same-anode segment flicker and a brief foreign anode.
        clear_mon();
        fa = rand_frame(1'b1);
        drive_digit(0, fa[6:0], DIG_CYC);
        drive_digit(1, fa[13:7], DIG_CYC);
        drive_digit(2, fa[20:14], 50);
        drive_digit(2, fa[20:14] ^ 7'h08, 5);
        drive_digit(2, fa[20:14], 45);
        drive_digit(3, fa[27:21], DIG_CYC);
        drive_digit(6, 7'h55, 6);
        for (int i = 4; i < 8; i++) drive_digit(i, fa[i*7 +: 7], DIG_CYC);
        blank(20);
        check_frame("t5_glitch", fa);
        check("t5_glitch_err", 64'(err_count_out), 64'(exp_err));

        // Scan stalls after digit 4.
        clear_mon();
        for (int i = 0; i < 5; i++) drive_digit(i, GLYPH[i], DIG_CYC);
        blank(TMO + 100);
        exp_err++;
        check("t6_timeout_err", 64'(err_count_out), 64'(exp_err));
        check("t6_no_frame", 64'(n_valid), 64'd0);

        // Reset while a frame is held and another is in progress.
        ready_in = 1'b0;
        clear_mon();
        fa = rand_frame(1'b0);
        scan_frame(fa);
        check("t6_held_before_reset", 64'(frame_valid_out), 64'd1);
        drive_digit(0, GLYPH[9], DIG_CYC);
        drive_digit(1, GLYPH[8], 40);
        @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        check("t6_reset_outputs", 64'({frame_valid_out, unknown_out, err_count_out, digit_frame_out}), 64'd0);
        check("t6_reset_segs", 64'(seg_frame_out), 64'd0);
        #3 rst_in = 1'b0;
        exp_err = 0;
        blank(10);
        ready_in = 1'b1;
        clear_mon();
        fa = rand_frame(1'b0);
        scan_frame(fa);
        check_frame("post_reset", fa);
        check("post_reset_err", 64'(err_count_out), 64'(exp_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
